axi_burst_master: RTL and testbench

//  Simplified AXI-style burst master. A start pulse issues one read or write burst.

---
 rtl/axi_burst_pkg.sv | 43 ++++
 rtl/axi_burst_slave.sv | 109 ++++++++++
 rtl/axi_burst_master.sv | 117 +++++++++++
 tb/tb_axi_burst_master.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_pkg.sv
// Shared definitions for the burst master and its companion slave:
// widths, command word layout, response codes, FSM states and beat selection.
package axi_burst_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int ID_W      = 4;
    localparam int LEN_W     = 4;
    localparam int BEATS_MAX = 16;

    // Command word layout: {ADDR[15:8], LEN[7:4], ID[3:0]}
    localparam int CMD_ID_LSB   = 0;
    localparam int CMD_LEN_LSB  = 4;
    localparam int CMD_ADDR_LSB = 8;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B
    } state_t;

    typedef enum logic [1:0] {
        SL_IDLE,
        SL_R,
        SL_W,
        SL_B
    } slave_state_t;

    // Pick beat idx out of the packed write payload (beat 0 in the low byte).
    function automatic logic [DATA_W-1:0] beat_sel(
        input logic [BEATS_MAX*DATA_W-1:0] data,
        input logic [LEN_W-1:0]            idx
    );
        return data[idx*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/axi_burst_slave.sv
// Companion slave: 256-byte memory serving one AR/R or AW/W/B burst at a time.
// stall forces the ready/valid outputs it controls low, to create backpressure.
module axi_burst_slave
    import axi_burst_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ar_valid,
    input  logic [15:0] ar_cmd,
    output logic        ar_ready,
    output logic        r_valid,
    output logic        r_last,
    output logic [8:0]  r_beat,
    input  logic        r_ready,
    input  logic        aw_valid,
    input  logic [11:0] aw_cmd,
    output logic        aw_ready,
    input  logic        w_valid,
    input  logic [7:0]  w_data,
    input  logic        w_last,
    output logic        w_ready,
    output logic        b_valid,
    output logic [4:0]  b_resp,
    input  logic        b_ready
);

    slave_state_t           sl_state, sl_nxt;
    logic [ADDR_W-1:0]      addr;
    logic [LEN_W-1:0]       len;
    logic [ID_W-1:0]        id;
    logic [LEN_W-1:0]       cnt;
    logic [ADDR_W-1:0]      idx;
    logic [DATA_W-1:0]      mem [256];

    assign idx = addr + {{(ADDR_W-LEN_W){1'b0}}, cnt};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sl_state <= SL_IDLE;
        else      sl_state <= sl_nxt;
    end

    // Next state and handshake outputs; reads win over writes when both are offered.
    always_comb begin
        sl_nxt   = sl_state;
        ar_ready = 1'b0;
        aw_ready = 1'b0;
        r_valid  = 1'b0;
        r_last   = 1'b0;
        r_beat   = '0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        b_resp   = '0;
        case (sl_state)
            SL_IDLE: begin
                ar_ready = !stall;
                aw_ready = !stall && !ar_valid;
                if (ar_valid && ar_ready)      sl_nxt = SL_R;
                else if (aw_valid && aw_ready) sl_nxt = SL_W;
            end
            SL_R: begin
                r_valid = !stall;
                r_last  = (cnt == len);
                r_beat  = {RESP_OKAY, mem[idx]};
                if (r_valid && r_ready && r_last) sl_nxt = SL_IDLE;
            end
            SL_W: begin
                w_ready = !stall;
                if (w_valid && w_ready && w_last) sl_nxt = SL_B;
            end
            SL_B: begin
                b_valid = 1'b1;
                b_resp  = {id, RESP_OKAY};
                if (b_ready) sl_nxt = SL_IDLE;
            end
            default: sl_nxt = SL_IDLE;
        endcase
    end

    // Latch burst parameters on address handshakes and step the beat counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr <= '0;
            len  <= '0;
            id   <= '0;
            cnt  <= '0;
        end else begin
            if (ar_valid && ar_ready) begin
                addr <= ar_cmd[CMD_ADDR_LSB +: ADDR_W];
                len  <= ar_cmd[CMD_LEN_LSB +: LEN_W];
                id   <= ar_cmd[CMD_ID_LSB +: ID_W];
                cnt  <= '0;
            end else if (aw_valid && aw_ready) begin
                addr <= aw_cmd[ID_W +: ADDR_W];
                id   <= aw_cmd[ID_W-1:0];
                cnt  <= '0;
            end else if ((r_valid && r_ready) || (w_valid && w_ready)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Memory contents survive reset so data written before a reset can be read back.
    always_ff @(posedge clk) begin
        if (w_valid && w_ready) mem[idx] <= w_data;
    end

endmodule

// File: rtl/axi_burst_master.sv
// Burst master: a start pulse issues one read (AR/R) or write (AW/W/B) burst.
// Single flat FSM; handshake outputs decode from state, captures are registered.
module axi_burst_master
    import axi_burst_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         en_,
    input  logic [15:0]  tb_R,
    input  logic [15:0]  tb_W,
    input  logic [127:0] INDATA,
    input  logic         ARREADY,
    output logic         ARVALID,
    output logic [15:0]  OUT,
    input  logic         RVALID,
    input  logic         RLAST,
    input  logic [8:0]   IN,
    output logic         RREADY,
    output logic [7:0]   RDATA,
    output logic         RRESP,
    input  logic         AWREADY,
    output logic         AWVALID,
    output logic [11:0]  AWOUT,
    input  logic         WREADY,
    output logic         WVALID,
    output logic [7:0]   WDATA,
    output logic         WLAST,
    input  logic         BVALID,
    input  logic [4:0]   BRESP,
    output logic         BREADY,
    output logic [4:0]   BOUT
);

    state_t            state, state_nxt;
    logic [15:0]       cmd;
    logic [LEN_W-1:0]  cnt;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [ID_W-1:0]   cmd_id;

    assign cmd_addr = cmd[CMD_ADDR_LSB +: ADDR_W];
    assign cmd_len  = cmd[CMD_LEN_LSB +: LEN_W];
    assign cmd_id   = cmd[CMD_ID_LSB +: ID_W];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next state and channel outputs; a read start wins over a simultaneous write start.
    always_comb begin
        state_nxt = state;
        ARVALID   = 1'b0;
        OUT       = '0;
        RREADY    = 1'b0;
        AWVALID   = 1'b0;
        AWOUT     = '0;
        WVALID    = 1'b0;
        WDATA     = '0;
        WLAST     = 1'b0;
        BREADY    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en)       state_nxt = ST_AR;
                else if (en_) state_nxt = ST_AW;
            end
            ST_AR: begin
                ARVALID = 1'b1;
                OUT     = cmd;
                if (ARREADY) state_nxt = ST_R;
            end
            ST_R: begin
                RREADY = 1'b1;
                if (RVALID && RLAST) state_nxt = ST_IDLE;
            end
            ST_AW: begin
                AWVALID = 1'b1;
                AWOUT   = {cmd_addr, cmd_id};
                if (AWREADY) state_nxt = ST_W;
            end
            ST_W: begin
                WVALID = 1'b1;
                WDATA  = beat_sel(INDATA, cnt);
                WLAST  = (cnt == cmd_len);
                if (WREADY && WLAST) state_nxt = ST_B;
            end
            ST_B: begin
                BREADY = 1'b1;
                if (BVALID) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Command latch, write beat counter and response captures.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd   <= '0;
            cnt   <= '0;
            RDATA <= '0;
            RRESP <= 1'b0;
            BOUT  <= '0;
        end else begin
            if (state == ST_IDLE) begin
                if (en)       cmd <= tb_R;
                else if (en_) cmd <= tb_W;
            end
            if (AWVALID && AWREADY)    cnt <= '0;
            else if (WVALID && WREADY) cnt <= cnt + 1'b1;
            if (RREADY && RVALID) {RRESP, RDATA} <= IN;
            if (BREADY && BVALID) BOUT <= BRESP;
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Master + slave back-to-back. Directed table of bursts, a mid-burst reset
// sequence, then randomized bursts with random backpressure, all checked
// against a byte-array memory model and per-channel handshake logs.
module tb_axi_burst_master;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0, en_ = 1'b0, stall = 1'b0;
    logic [15:0]  tb_R = '0, tb_W = '0;
    logic [127:0] INDATA = '0;
    logic         ARREADY, ARVALID, RVALID, RLAST, RREADY, RRESP;
    logic         AWREADY, AWVALID, WREADY, WVALID, WLAST, BVALID, BREADY;
    logic [15:0]  OUT;
    logic [8:0]   IN;
    logic [7:0]   RDATA, WDATA;
    logic [11:0]  AWOUT;
    logic [4:0]   BRESP, BOUT;

    axi_burst_master dut (
        .clk(clk), .rst(rst), .en(en), .en_(en_), .tb_R(tb_R), .tb_W(tb_W), .INDATA(INDATA),
        .ARREADY(ARREADY), .ARVALID(ARVALID), .OUT(OUT),
        .RVALID(RVALID), .RLAST(RLAST), .IN(IN), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .AWREADY(AWREADY), .AWVALID(AWVALID), .AWOUT(AWOUT),
        .WREADY(WREADY), .WVALID(WVALID), .WDATA(WDATA), .WLAST(WLAST),
        .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY), .BOUT(BOUT)
    );

    axi_burst_slave slv (
        .clk(clk), .rst(rst), .stall(stall),
        .ar_valid(ARVALID), .ar_cmd(OUT), .ar_ready(ARREADY),
        .r_valid(RVALID), .r_last(RLAST), .r_beat(IN), .r_ready(RREADY),
        .aw_valid(AWVALID), .aw_cmd(AWOUT), .aw_ready(AWREADY),
        .w_valid(WVALID), .w_data(WDATA), .w_last(WLAST), .w_ready(WREADY),
        .b_valid(BVALID), .b_resp(BRESP), .b_ready(BREADY)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Handshake logs and reference memory
    logic [15:0] ar_q[$];
    logic [11:0] aw_q[$];
    logic [8:0]  w_q[$];   // {last, data}
    logic [9:0]  r_q[$];   // {resp, last, data}
    logic [4:0]  b_q[$];
    logic [7:0]  mem_m [256];

    bit rand_stall = 0;
    int stall_left = 0;

    logic [55:0] outs;
    assign outs = {ARVALID, OUT, RREADY, RDATA, RRESP, AWVALID, AWOUT,
                   WVALID, WDATA, WLAST, BREADY, BOUT};

    // Backpressure generator: forced windows or random stalls.
    always @(negedge clk) begin
        if (stall_left > 0) begin
            stall = 1'b1;
            stall_left--;
        end else begin
            stall = rand_stall && ($urandom_range(0, 2) == 0);
        end
    end

    // Monitor: log handshakes that will complete at the next rising edge and
    // check VALID/payload stability while a transfer is held off.
    bit          p_ar = 0, p_aw = 0, p_w = 0;
    logic [15:0] p_out;
    logic [11:0] p_awout;
    logic [8:0]  p_wbeat;
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            p_ar = 0; p_aw = 0; p_w = 0;
        end else begin
            if (p_ar) chk("ar_hold", {ARVALID, OUT}, {1'b1, p_out});
            if (p_aw) chk("aw_hold", {AWVALID, AWOUT}, {1'b1, p_awout});
            if (p_w)  chk("w_hold", {WVALID, WLAST, WDATA}, {1'b1, p_wbeat});
            if (ARVALID && ARREADY) ar_q.push_back(OUT);
            if (AWVALID && AWREADY) aw_q.push_back(AWOUT);
            if (WVALID && WREADY)   w_q.push_back({WLAST, WDATA});
            if (RVALID && RREADY)   r_q.push_back({IN[8], RLAST, IN[7:0]});
            if (BVALID && BREADY)   b_q.push_back(BRESP);
            p_ar = ARVALID && !ARREADY;  p_out   = OUT;
            p_aw = AWVALID && !AWREADY;  p_awout = AWOUT;
            p_w  = WVALID && !WREADY;    p_wbeat = {WLAST, WDATA};
        end
    end

    function automatic logic [127:0] pat();
        logic [127:0] d;
        for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'((i % 4) + 1);
        return d;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One burst from start pulse to return to idle, checked against the model.
    task automatic run_txn(input bit is_wr, input logic [15:0] cmd, input logic [127:0] data,
                           input int stall_n, input int poke, input bit both,
                           output logic [8:0] fin);
        int         len  = int'(cmd[7:4]);
        int         addr = int'(cmd[15:8]);
        logic [3:0] id   = cmd[3:0];
        bit         done = 0;
        bit         wstall_done = 0;
        ar_q.delete(); aw_q.delete(); w_q.delete(); r_q.delete(); b_q.delete();
        @(negedge clk);
        INDATA     = data;
        stall_left = stall_n;
        if (is_wr) begin
            tb_W = cmd; en_ = 1'b1;
        end else begin
            tb_R = cmd; en = 1'b1;
            if (both) begin tb_W = 16'h55F5; en_ = 1'b1; end
        end
        @(negedge clk);
        en = 1'b0; en_ = 1'b0;
        #2;
        chk("start_valid", {ARVALID, AWVALID}, is_wr ? 2'b01 : 2'b10);
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == poke) begin tb_W = 16'h66F6; en_ = 1'b1; end
            else en_ = 1'b0;
            #2;
            if (is_wr && stall_n > 0 && !wstall_done && w_q.size() == 2) begin
                stall_left  = 4;
                wstall_done = 1;
            end
            done = is_wr ? (b_q.size() > 0) : (r_q.size() > 0 && r_q[$][8]);
        end
        en_ = 1'b0;
        chk("txn_done", done, 1'b1);
        @(negedge clk);
        #2;
        if (is_wr) begin
            chk("aw_count", aw_q.size(), 1);
            if (aw_q.size() > 0) chk("aw_payload", aw_q[0], {cmd[15:8], id});
            chk("w_count", w_q.size(), len + 1);
            for (int i = 0; i < w_q.size() && i <= len; i++)
                chk("w_beat", w_q[i], {(i == len), data[i*8 +: 8]});
            chk("b_count", b_q.size(), 1);
            chk("bout", BOUT, {id, 1'b0});
            chk("no_ar_in_write", ar_q.size(), 0);
            fin = {4'b0, BOUT};
            for (int i = 0; i <= len; i++) mem_m[8'(addr + i)] = data[i*8 +: 8];
        end else begin
            chk("ar_count", ar_q.size(), 1);
            if (ar_q.size() > 0) chk("ar_payload", ar_q[0], cmd);
            chk("r_count", r_q.size(), len + 1);
            for (int i = 0; i < r_q.size() && i <= len; i++)
                chk("r_beat", r_q[i], {1'b0, (i == len), mem_m[8'(addr + i)]});
            chk("rdata_final", {RRESP, RDATA}, {1'b0, mem_m[8'(addr + len)]});
            chk("no_aw_in_read", aw_q.size(), 0);
            fin = {RRESP, RDATA};
        end
        chk("idle_after", {ARVALID, AWVALID, WVALID, RREADY, BREADY}, 5'b0);
    endtask

    typedef struct {
        bit          is_wr;
        logic [15:0] cmd;
        bit          pre_reset;
        int          stall_n;
        int          poke;
        bit          both;
        logic [8:0]  exp_fin;   // write: {0, BOUT}; read: {RRESP, RDATA}
    } vec_t;

    vec_t        tbl[7];
    logic [8:0]  fin;
    logic [127:0] d;

    initial begin
        tbl[0] = '{1'b1, 16'h01F1, 1'b0, 0, -1, 1'b0, 9'h002};
        tbl[1] = '{1'b0, 16'h01F1, 1'b1, 0, -1, 1'b0, 9'h004};
        tbl[2] = '{1'b1, 16'h20F3, 1'b0, 5, -1, 1'b0, 9'h006};
        tbl[3] = '{1'b0, 16'h20F3, 1'b0, 5, -1, 1'b0, 9'h004};
        tbl[4] = '{1'b0, 16'h0111, 1'b0, 0,  2, 1'b0, 9'h002};
        tbl[5] = '{1'b0, 16'h2207, 1'b0, 0, -1, 1'b1, 9'h003};
        tbl[6] = '{1'b1, 16'h300A, 1'b0, 0, -1, 1'b0, 9'h014};

        repeat (3) @(negedge clk);
        #2;
        chk("reset_outputs", outs, '0);
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 7; k++) begin
            if (tbl[k].pre_reset) begin
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                #2;
                chk("reset_idle", outs, '0);
                rst = 1'b1;
            end
            run_txn(tbl[k].is_wr, tbl[k].cmd, pat(), tbl[k].stall_n, tbl[k].poke, tbl[k].both, fin);
            chk("table_final", fin, tbl[k].exp_fin);
        end

        // Reset in the middle of a 16-beat write, then a clean write from beat 0.
        ar_q.delete(); aw_q.delete(); w_q.delete(); r_q.delete(); b_q.delete();
        @(negedge clk);
        INDATA = rnd128();
        tb_W   = 16'h80F5;
        en_    = 1'b1;
        @(negedge clk);
        en_ = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (w_q.size() >= 5) break;
        end
        chk("mid_reset_reached", (w_q.size() >= 5), 1'b1);
        rst = 1'b0;
        #2;
        chk("mid_reset_outputs", outs, '0);
        @(negedge clk);
        rst = 1'b1;
        run_txn(1'b1, 16'h80F5, rnd128(), 0, -1, 1'b0, fin);
        chk("post_reset_bout", fin, 9'h00A);

        // Randomized: fill all of memory, then mixed bursts, with random stalls.
        rand_stall = 1;
        for (int k = 0; k < 16; k++) begin
            d = rnd128();
            run_txn(1'b1, {8'(k * 16), 4'hF, 4'($urandom)}, d, 0, -1, 1'b0, fin);
        end
        for (int k = 0; k < 30; k++) begin
            d = rnd128();
            run_txn(1'($urandom), 16'($urandom), d, 0, -1, 1'b0, fin);
        end
        rand_stall = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
